// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: drives data-memory loads/stores over a req/ack handshake,
// steers byte lanes, extends load data and registers the MEM/WB outputs.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        InValid,
  input  logic [31:0] ALUResultIn,
  input  logic [31:0] StoreData,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemUnsigned,
  input  logic        MemALUSelIn,
  input  logic        RegWriteIn,
  input  logic [4:0]  WriteRegIn,
  output logic        Stall,
  output logic        DMemReq,
  output logic        DMemWE,
  output logic [31:0] DMemAddr,
  output logic [31:0] DMemWData,
  output logic [3:0]  DMemByteEn,
  input  logic [31:0] DMemRData,
  input  logic        DMemAck,
  output logic [31:0] MEMRead,
  output logic [31:0] ALUResult,
  output logic        MemALUSel,
  output logic        RegWrite,
  output logic [4:0]  WriteReg,
  output logic        WBValid,
  output logic        MisalignErr,
  output logic        BusErr
);

  // state  | meaning
  // S_IDLE | accepting a new instruction from EX/MEM
  // S_WAIT | memory request outstanding, waiting for DMemAck or timeout
  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [CW-1:0] wait_cnt;

  logic        mem_op;
  logic        misalign;
  logic        timeout;
  logic [3:0]  be_nxt;
  logic [31:0] wd_nxt;

  logic        pend_rw;
  logic [1:0]  pend_size;
  logic [1:0]  pend_off;
  logic        pend_uns;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  always_comb begin
    mem_op   = MemRead | MemWrite;
    misalign = 1'b0;
    be_nxt   = 4'b1111;
    wd_nxt   = StoreData;
    case (MemSize)
      2'b00: begin
        be_nxt = 4'b0001 << ALUResultIn[1:0];
        wd_nxt = {4{StoreData[7:0]}};
      end
      2'b01: begin
        misalign = ALUResultIn[0];
        be_nxt   = ALUResultIn[1] ? 4'b1100 : 4'b0011;
        wd_nxt   = {2{StoreData[15:0]}};
      end
      default: misalign = |ALUResultIn[1:0];
    endcase
  end

  // Lane select and extension use the fields captured when the request went out.
  always_comb begin
    case (pend_off)
      2'd1:    ld_byte = DMemRData[15:8];
      2'd2:    ld_byte = DMemRData[23:16];
      2'd3:    ld_byte = DMemRData[31:24];
      default: ld_byte = DMemRData[7:0];
    endcase
    ld_half = pend_off[1] ? DMemRData[31:16] : DMemRData[15:0];
    case (pend_size)
      2'b00:   ld_ext = {{24{~pend_uns & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{~pend_uns & ld_half[15]}}, ld_half};
      default: ld_ext = DMemRData;
    endcase
  end

  assign timeout = (wait_cnt == CNT_LAST);

  always_comb begin
    if (state == S_IDLE) Stall = InValid & mem_op & ~misalign;
    else                 Stall = ~DMemAck & ~timeout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      DMemReq     <= 1'b0;
      DMemWE      <= 1'b0;
      DMemAddr    <= '0;
      DMemWData   <= '0;
      DMemByteEn  <= '0;
      MEMRead     <= '0;
      ALUResult   <= '0;
      MemALUSel   <= 1'b0;
      RegWrite    <= 1'b0;
      WriteReg    <= '0;
      WBValid     <= 1'b0;
      MisalignErr <= 1'b0;
      BusErr      <= 1'b0;
      pend_rw     <= 1'b0;
      pend_size   <= '0;
      pend_off    <= '0;
      pend_uns    <= 1'b0;
    end else begin
      WBValid     <= 1'b0;
      RegWrite    <= 1'b0;
      MisalignErr <= 1'b0;
      BusErr      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (InValid) begin
            ALUResult <= ALUResultIn;
            MemALUSel <= MemALUSelIn;
            WriteReg  <= WriteRegIn;
            MEMRead   <= '0;
            if (!mem_op) begin
              WBValid  <= 1'b1;
              RegWrite <= RegWriteIn;
            end else if (misalign) begin
              WBValid     <= 1'b1;
              MisalignErr <= 1'b1;
            end else begin
              state      <= S_WAIT;
              wait_cnt   <= '0;
              DMemReq    <= 1'b1;
              DMemWE     <= MemWrite;
              DMemAddr   <= {ALUResultIn[31:2], 2'b00};
              DMemWData  <= wd_nxt;
              DMemByteEn <= be_nxt;
              pend_rw    <= RegWriteIn & ~MemWrite;
              pend_size  <= MemSize;
              pend_off   <= ALUResultIn[1:0];
              pend_uns   <= MemUnsigned;
            end
          end
        end
        S_WAIT: begin
          if (DMemAck) begin
            state    <= S_IDLE;
            DMemReq  <= 1'b0;
            WBValid  <= 1'b1;
            RegWrite <= pend_rw;
            MEMRead  <= DMemWE ? 32'd0 : ld_ext;
          end else if (timeout) begin
            state   <= S_IDLE;
            DMemReq <= 1'b0;
            WBValid <= 1'b1;
            BusErr  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline MEM stage. Sits between the EX/MEM register and the write-back mux.
- Performs loads and stores to the data memory over a req/ack handshake. Handles byte, half and word sizes with lane steering and sign or zero extension.
- Stalls upstream while an access is outstanding.
- Registers the MEM/WB outputs that feed the write-back selection: MEMRead, ALUResult, MemALUSel, RegWrite and WriteReg.

Parameters:
- TIMEOUT_CYCLES, 64: WAIT cycles allowed without DMemAck before the access is aborted as a bus error.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- InValid  in  1  EX/MEM register holds a valid instruction
- ALUResultIn  in  32  ALU result; this is the byte address for memory ops
- StoreData  in  32  store operand, right-aligned
- MemRead  in  1  load op
- MemWrite  in  1  store op
- MemSize  in  2  00 byte, 01 half, 10 word (11 is treated as word)
- MemUnsigned  in  1  zero-extend loads when 1, sign-extend when 0
- MemALUSelIn  in  1  1 = write-back takes memory data, 0 = ALU result
- RegWriteIn  in  1  instruction writes the register file
- WriteRegIn  in  5  destination register
- Stall  out  1  upstream must hold the EX/MEM register
- DMemReq  out  1  memory request, registered
- DMemWE  out  1  1 = write
- DMemAddr  out  32  word-aligned address {addr[31:2],2'b00}
- DMemWData  out  32  lane-replicated store data
- DMemByteEn  out  4  byte-lane enables
- DMemRData  in  32  read data, valid when DMemAck=1
- DMemAck  in  1  access complete
- MEMRead  out  32  extended load data to write-back
- ALUResult  out  32  registered ALU result to write-back
- MemALUSel  out  1  registered select
- RegWrite  out  1  registered write enable (forced 0 on store or error)
- WriteReg  out  5  registered destination register
- WBValid  out  1  MEM/WB register holds a valid instruction
- MisalignErr  out  1  one-cycle pulse, aligned with WBValid
- BusErr  out  1  one-cycle pulse, aligned with WBValid

Behaviour:
- Reset (synchronous):
  - State goes to IDLE and the timeout counter clears.
  - All outputs go to 0.
  - A reset during WAIT aborts the access: DMemReq is 0 after that edge and no WB result is produced.
- FSM has two states, IDLE and WAIT.
- IDLE, InValid=0: next edge WBValid=0 and RegWrite=0; the data registers hold. Stall=0.
- IDLE, InValid=1, no mem op:
  - Next edge loads ALUResult, MemALUSel, RegWrite and WriteReg from the inputs, MEMRead=0, WBValid=1.
  - Stall=0. Latency is 1 cycle.
- IDLE, mem op (MemWrite wins if both MemRead and MemWrite are set):
  - Misaligned case: half with addr[0]=1, or word with addr[1:0]!=0.
    - No memory access is made and Stall=0.
    - Next edge WBValid=1, RegWrite=0, MisalignErr=1.
  - Aligned case:
    - Stall=1 combinationally.
    - Next edge captures address, data, enables and WB fields, sets DMemReq=1, and moves to WAIT.
- WAIT:
  - DMemReq, DMemWE, DMemAddr, DMemWData and DMemByteEn are held stable. Inputs are ignored. Stall = !DMemAck && !timeout.
  - On DMemAck=1:
    - Stall=0 in that same cycle, so upstream advances.
    - Next edge: DMemReq=0, WBValid=1, extended load data goes to MEMRead, state returns to IDLE.
  - Store completion: RegWrite=0 and MEMRead=0.
  - Timeout: the counter increments every WAIT cycle without ack. When count==TIMEOUT_CYCLES-1 and no ack:
    - Stall=0 that cycle.
    - Next edge: DMemReq=0, WBValid=1, RegWrite=0, BusErr=1, state returns to IDLE.
- DMemAck while in IDLE is ignored.
- A back-to-back memory op is accepted in the IDLE cycle following completion. There is no dead cycle beyond that IDLE cycle.
- Store lanes (little-endian):
  - Byte: ByteEn = 1<<addr[1:0], WData = {4{sd[7:0]}}.
  - Half: ByteEn = addr[1] ? 1100 : 0011, WData = {2{sd[15:0]}}.
  - Word: ByteEn = 1111, WData = sd.
- Loads:
  - DMemWE=0 and ByteEn uses the same pattern as stores.
  - The selected lane is extended to 32 bits: sign-extended when MemUnsigned=0, zero-extended when MemUnsigned=1.
- Latency: load/store = 2 cycles + memory wait. With the ack in the first WAIT cycle, WB is valid 2 edges after presentation.

Test Plan:
- ALU op (InValid=1, RegWriteIn=1, ALUResultIn=0x1234, WriteRegIn=5) -> after 1 edge: WBValid=1, ALUResult=0x1234, RegWrite=1, WriteReg=5, Stall never high.
- LB addr 0x103 signed, DMemRData=0x80FFFFFF, ack in first WAIT cycle -> DMemAddr=0x100, ByteEn=1000, Stall high for 1 cycle, MEMRead=0xFFFFFF80; repeat with MemUnsigned=1 -> 0x00000080.
- SH addr 0x202, StoreData=0xABCD1234, ack after 3 wait cycles -> DMemWE=1, ByteEn=1100, WData=0x12341234, Stall high for 4 cycles, RegWrite=0.
- LW addr 0x302 -> no DMemReq, MisalignErr=1 for 1 cycle, RegWrite=0, WBValid=1.
- LW with DMemAck held 0 -> after TIMEOUT_CYCLES in WAIT: BusErr pulse, DMemReq=0, Stall=0, FSM back in IDLE; a following LW completes normally.
- reset asserted in WAIT -> next cycle: DMemReq=0, Stall=0, WBValid=0, all outputs 0; a late DMemAck is ignored.
